// File: rtl/calc_pkg.sv
// Shared constants and types for the command sequencer and its ALU.
package calc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned STAT_W = 5;
  localparam int unsigned RD_W   = 2;

  // Command opcodes
  localparam logic [CMD_W-1:0] CMD_NOP    = 3'd0;
  localparam logic [CMD_W-1:0] CMD_LDA_LO = 3'd1;
  localparam logic [CMD_W-1:0] CMD_LDA_HI = 3'd2;
  localparam logic [CMD_W-1:0] CMD_LDB_LO = 3'd3;
  localparam logic [CMD_W-1:0] CMD_LDB_HI = 3'd4;
  localparam logic [CMD_W-1:0] CMD_SETOP  = 3'd5;
  localparam logic [CMD_W-1:0] CMD_EXEC   = 3'd6;
  localparam logic [CMD_W-1:0] CMD_CTRL   = 3'd7;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ALU operation codes; anything above OP_MAX is invalid
  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_AND  = 4'd1;
  localparam logic [OP_W-1:0] OP_OR   = 4'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd3;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd4;
  localparam logic [OP_W-1:0] OP_PASS = 4'd5;
  localparam logic [OP_W-1:0] OP_INC  = 4'd6;
  localparam logic [OP_W-1:0] OP_DEC  = 4'd7;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd9;
  localparam logic [OP_W-1:0] OP_SAR  = 4'd10;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd11;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd12;
  localparam logic [OP_W-1:0] OP_MAX  = 4'd12;

  // Status bit positions
  localparam int unsigned ST_INV = 0;
  localparam int unsigned ST_Z   = 1;
  localparam int unsigned ST_S   = 2;
  localparam int unsigned ST_C   = 3;
  localparam int unsigned ST_O   = 4;

  // Read-port select codes
  localparam logic [RD_W-1:0] RD_RES_LO = 2'd0;
  localparam logic [RD_W-1:0] RD_RES_HI = 2'd1;
  localparam logic [RD_W-1:0] RD_STAT   = 2'd2;
  localparam logic [RD_W-1:0] RD_CTRL   = 2'd3;

endpackage

// File: rtl/calc_seq.sv
// Command-driven sequencer: byte-wise operand loads, one ALU evaluation per
// EXEC, byte-wise result readback, optional accumulator chaining.
module calc_seq
  import calc_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter bit          CHAIN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [7:0]        din,
  output logic [OP_W-1:0]   alu_sel,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic [DW-1:0]     alu_y,
  input  logic [STAT_W-1:0] alu_status,
  output logic [7:0]        dout,
  output logic              res_valid,
  output logic              err
);

  state_e              state_q, state_d;
  logic [DW-1:0]       reg_a_q, reg_a_d;
  logic [DW-1:0]       reg_b_q, reg_b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DW-1:0]       res_q, res_d;
  logic [STAT_W-1:0]   stat_q, stat_d;
  logic [RD_W-1:0]     rd_sel_q, rd_sel_d;
  logic                err_q, err_d;
  logic                sticky_q, sticky_d;
  logic                chain_q, chain_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                res_valid_q, res_valid_d;
  logic [OP_W-1:0]     alu_sel_q, alu_sel_d;
  logic [7:0]          dout_q, dout_d;

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign alu_sel   = alu_sel_q;
  assign alu_a     = reg_a_q;
  assign alu_b     = reg_b_q;
  assign dout      = dout_q;
  assign err       = err_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      op_q        <= '0;
      res_q       <= '0;
      stat_q      <= '0;
      rd_sel_q    <= '0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      chain_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      alu_sel_q   <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      stat_q      <= stat_d;
      rd_sel_q    <= rd_sel_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      chain_q     <= chain_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      alu_sel_q   <= alu_sel_d;
      dout_q      <= dout_d;
    end
  end

  // Command decode, FSM transitions and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    op_d     = op_q;
    res_d    = res_q;
    stat_d   = stat_q;
    rd_sel_d = rd_sel_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    chain_d  = chain_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_NOP:    ;
            CMD_LDA_LO: reg_a_d[BYTE_W-1:0]  = din;
            CMD_LDA_HI: reg_a_d[DW-1:BYTE_W] = din;
            CMD_LDB_LO: reg_b_d[BYTE_W-1:0]  = din;
            CMD_LDB_HI: reg_b_d[DW-1:BYTE_W] = din;
            CMD_SETOP:  op_d = din[OP_W-1:0];
            CMD_EXEC: begin
              chain_d = din[0] & CHAIN_EN;
              state_d = ST_EXEC;
            end
            CMD_CTRL: begin
              rd_sel_d = din[RD_W-1:0];
              if (din[7]) begin
                err_d    = 1'b0;
                sticky_d = 1'b0;
              end
            end
          endcase
        end
      end
      ST_EXEC: begin
        res_d    = alu_y;
        stat_d   = alu_status;
        err_d    = err_q | alu_status[ST_INV];
        sticky_d = sticky_q | alu_status[ST_C];
        if (chain_q) begin
          reg_a_d = alu_y;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs registered from next-state values so they line up with the state
    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
    alu_sel_d   = (state_d == ST_EXEC) ? op_d : '0;

    case (rd_sel_d)
      RD_RES_LO: dout_d = res_d[BYTE_W-1:0];
      RD_RES_HI: dout_d = res_d[DW-1:BYTE_W];
      RD_STAT:   dout_d = {3'b000, stat_d};
      default:   dout_d = {err_d, sticky_d, 2'b00, op_d};
    endcase
  end

endmodule

// File: tb/tb_calc_seq.sv
// Testbench for calc_seq with a behavioural ALU and an expected-result queue.
module tb_calc_seq;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [7:0]  din;

  logic        cmd_ready, res_valid, err;
  logic [3:0]  alu_sel;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [4:0]  alu_status;
  logic [7:0]  dout;

  logic        cmd_ready_nc, res_valid_nc, err_nc;
  logic [3:0]  alu_sel_nc;
  logic [15:0] alu_a_nc, alu_b_nc, alu_y_nc;
  logic [4:0]  alu_status_nc;
  logic [7:0]  dout_nc;

  int checks   = 0;
  int failures = 0;
  logic [20:0] exp_q[$];
  logic [1:0]  rd_m;
  logic [3:0]  op_m;

  always #5 clk = ~clk;

  // Behavioural ALU returning {status, y}
  function automatic logic [20:0] alu_model(input logic [3:0] sel,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] w;
    logic        inv, c, o, z, s;
    w = '0; inv = 1'b0; c = 1'b0; o = 1'b0;
    case (sel)
      4'd1:  w = {1'b0, a & b};
      4'd2:  w = {1'b0, a | b};
      4'd3:  w = {1'b0, a ^ b};
      4'd4:  w = {1'b0, ~a};
      4'd5:  w = {1'b0, a};
      4'd6:  begin w = {1'b0, a} + 17'd1; o = (a == 16'h7FFF); end
      4'd7:  w = {1'b0, a - 16'd1};
      4'd11: begin
        w = {1'b0, a} + {1'b0, b};
        o = (a[15] == b[15]) && (w[15] != a[15]);
      end
      4'd12: begin
        w = {1'b0, a} - {1'b0, b};
        o = (a[15] != b[15]) && (w[15] != a[15]);
      end
      4'd13, 4'd14, 4'd15: inv = 1'b1;
      default: w = '0;
    endcase
    c = w[16];
    z = (w[15:0] == 16'h0000);
    s = w[15];
    return {o, c, s, z, inv, w[15:0]};
  endfunction

  assign {alu_status, alu_y}       = alu_model(alu_sel, alu_a, alu_b);
  assign {alu_status_nc, alu_y_nc} = alu_model(alu_sel_nc, alu_a_nc, alu_b_nc);

  calc_seq #(.DW(16), .CHAIN_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .din(din), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_status(alu_status), .dout(dout),
    .res_valid(res_valid), .err(err)
  );

  calc_seq #(.DW(16), .CHAIN_EN(1'b0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_nc),
    .cmd(cmd), .din(din), .alu_sel(alu_sel_nc), .alu_a(alu_a_nc), .alu_b(alu_b_nc),
    .alu_y(alu_y_nc), .alu_status(alu_status_nc), .dout(dout_nc),
    .res_valid(res_valid_nc), .err(err_nc)
  );

  // Present a command and hold it until accepted; returns 1ns after the accept edge
  task automatic send(input logic [2:0] c, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd = c; din = d;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL send_timeout: cmd=%0d never accepted", c);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = CMD_NOP; din = 8'h00;
    if (c == CMD_SETOP) op_m = d[3:0];
    if (c == CMD_CTRL)  rd_m = d[1:0];
  endtask

  task automatic read_chk(input logic [1:0] sel, input logic [7:0] exp, input string name);
    send(CMD_CTRL, {6'b0, sel});
    checks++;
    if (dout !== exp) begin
      failures++;
      $display("FAIL %s: dout got %h expected %h", name, dout, exp);
    end
  endtask

  // EXEC with expected result queued, then checked when res_valid shows up
  task automatic exec_chk(input logic chain, input logic [15:0] exp_res,
                          input logic [4:0] exp_stat, input string name);
    int n = 0;
    logic [20:0] e;
    logic [7:0]  exp_d;
    send(CMD_EXEC, {7'b0, chain});
    exp_q.push_back({exp_stat, exp_res});
    checks++;
    if (alu_sel !== op_m) begin
      failures++;
      $display("FAIL %s_alu_sel: got %h expected %h", name, alu_sel, op_m);
    end
    while (!res_valid && n < 5) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL %s_latency: res_valid after %0d cycles expected 1", name, n);
    end
    if (res_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (rd_m)
        2'd0:    exp_d = e[7:0];
        2'd1:    exp_d = e[15:8];
        default: exp_d = {3'b000, e[20:16]};
      endcase
      checks++;
      if (dout !== exp_d || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_result: dout=%h ready=%b expected dout=%h ready=0",
                 name, dout, cmd_ready, exp_d);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_pulse: res_valid=%b ready=%b expected 0/1", name, res_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP; din = 8'h00;
    rd_m = 2'd0; op_m = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if ({cmd_ready, res_valid, err, alu_sel, dout, alu_a, alu_b} !== {3'b100, 4'h0, 8'h00, 32'h0}) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b err=%b sel=%h dout=%h a=%h b=%h expected 1 0 0 0 00 0000 0000",
               cmd_ready, res_valid, err, alu_sel, dout, alu_a, alu_b);
    end
  endtask

  task automatic test_add();
    send(CMD_LDA_LO, 8'h34); send(CMD_LDA_HI, 8'h12);
    send(CMD_LDB_LO, 8'h01); send(CMD_LDB_HI, 8'h00);
    send(CMD_SETOP, 8'd11);
    checks++;
    if (alu_a !== 16'h1234 || alu_b !== 16'h0001) begin
      failures++;
      $display("FAIL load_ab: a=%h b=%h expected 1234 0001", alu_a, alu_b);
    end
    send(CMD_CTRL, 8'h00);
    exec_chk(1'b0, 16'h1235, 5'b00000, "add");
    read_chk(2'd1, 8'h12, "add_res_hi");
    read_chk(2'd2, 8'h00, "add_stat");
    read_chk(2'd0, 8'h35, "add_res_lo");
    read_chk(2'd3, 8'h0B, "add_ctrl");
  endtask

  task automatic test_carry();
    send(CMD_LDA_LO, 8'hFF); send(CMD_LDA_HI, 8'hFF);
    send(CMD_CTRL, 8'h00);
    exec_chk(1'b0, 16'h0000, 5'b01010, "carry");
    read_chk(2'd2, 8'h0A, "carry_stat");
    read_chk(2'd3, 8'h4B, "carry_sticky");
    read_chk(2'd3 | 2'd0, 8'h4B, "carry_sticky_hold");
    send(CMD_CTRL, 8'h83);
    checks++;
    if (dout !== 8'h0B) begin
      failures++;
      $display("FAIL sticky_clear: dout got %h expected 0b", dout);
    end
  endtask

  task automatic test_invalid();
    send(CMD_SETOP, 8'd13);
    send(CMD_CTRL, 8'h02);
    exec_chk(1'b0, 16'h0000, 5'b00011, "invalid");
    read_chk(2'd3, 8'h8D, "invalid_err");
    send(CMD_LDA_LO, 8'h01); send(CMD_LDA_HI, 8'h00);
    send(CMD_SETOP, 8'd11);
    send(CMD_CTRL, 8'h00);
    exec_chk(1'b0, 16'h0002, 5'b00000, "after_invalid");
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err got %b expected 1", err);
    end
    send(CMD_CTRL, 8'h80);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err got %b expected 0", err);
    end
  endtask

  task automatic test_chain();
    send(CMD_LDA_LO, 8'h05); send(CMD_LDA_HI, 8'h00);
    send(CMD_SETOP, 8'd6);
    exec_chk(1'b1, 16'h0006, 5'b00000, "chain1");
    exec_chk(1'b1, 16'h0007, 5'b00000, "chain2");
    checks++;
    if (alu_a !== 16'h0007) begin
      failures++;
      $display("FAIL chain_reg_a: got %h expected 0007", alu_a);
    end
    checks++;
    if (alu_a_nc !== 16'h0005 || dout_nc !== 8'h06) begin
      failures++;
      $display("FAIL nochain: reg_a=%h dout=%h expected 0005 06", alu_a_nc, dout_nc);
    end
    checks++;
    if ({cmd_ready_nc, res_valid_nc, err_nc} !== 3'b100 || alu_b_nc !== 16'h0001) begin
      failures++;
      $display("FAIL nochain_ctl: rdy/val/err=%b%b%b b=%h expected 100 0001",
               cmd_ready_nc, res_valid_nc, err_nc, alu_b_nc);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] e;
    int bad = 0;
    send(CMD_EXEC, 8'h00);
    exp_q.push_back({5'b00000, 16'h0008});
    cmd_valid = 1'b1; cmd = CMD_LDB_LO; din = 8'hAA;
    @(posedge clk); #1;
    if (alu_b !== 16'h0001 || cmd_ready !== 1'b0 || res_valid !== 1'b1) bad++;
    if (res_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dout !== e[7:0]) begin
        failures++;
        $display("FAIL b2b_result: dout got %h expected %h", dout, e[7:0]);
      end
    end
    @(posedge clk); #1;
    if (alu_b !== 16'h0001 || cmd_ready !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_busy: %0d busy-cycle violations, b=%h expected 0001", bad, alu_b);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = CMD_NOP; din = 8'h00;
    checks++;
    if (alu_b !== 16'h00AA) begin
      failures++;
      $display("FAIL b2b_accept: b got %h expected 00aa", alu_b);
    end
  endtask

  task automatic test_reset_mid_exec();
    int pulses = 0;
    send(CMD_SETOP, 8'd13);
    send(CMD_CTRL, 8'h02);
    exec_chk(1'b0, 16'h0000, 5'b00011, "pre_reset_inv");
    send(CMD_SETOP, 8'd11);
    send(CMD_EXEC, 8'h01);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_m = 2'd0;
    checks++;
    if ({cmd_ready, res_valid, err, dout, alu_a} !== {3'b100, 8'h00, 16'h0000}) begin
      failures++;
      $display("FAIL mid_reset: ready=%b valid=%b err=%b dout=%h a=%h expected 1 0 0 00 0000",
               cmd_ready, res_valid, err, dout, alu_a);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (res_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_pulse: pulses=%0d pending=%0d expected 0 0", pulses, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_invalid();
    test_chain();
    test_back_to_back();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
